// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for uart_tx_sched: FSM state encodings and default UART register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_POLL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [3:0]  DEF_DATA_ADDR = 4'd0;
    localparam logic [3:0]  DEF_BAUD_ADDR = 4'd1;
    localparam logic [3:0]  DEF_STAT_ADDR = 4'd2;
    localparam int          DEF_TXRDY_BIT = 1;
    localparam logic [31:0] DEF_BAUD_CFG  = 32'd3;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from ptr+1 (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on idx/any.
// Ports: req (request vector), ptr (last served index), idx (chosen index), any (some request set).
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      idx,
    output logic            any
);

    // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1) so the
    // nearest set bit is the last assignment and wins, without needing a break.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = 3'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters: baud write after reset, then round-robin byte writes.
// Latency: request seen in IDLE at t -> status poll at t+1 -> data write and req_ready at t+2 (3 cycles/byte minimum).
// Backpressure: polls UART status every cycle until TXRDY is set; requesters hold valid/data until req_ready.
// Ports: clk/reset; req_valid/req_data/req_ready per requester; grant_id, cfg_done, busy status;
//        cs/wen/addr/din/dout UART register bus.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int          NREQ      = 4,
    parameter logic [31:0] BAUD_CFG  = DEF_BAUD_CFG,
    parameter logic [3:0]  DATA_ADDR = DEF_DATA_ADDR,
    parameter logic [3:0]  BAUD_ADDR = DEF_BAUD_ADDR,
    parameter logic [3:0]  STAT_ADDR = DEF_STAT_ADDR,
    parameter int          TXRDY_BIT = DEF_TXRDY_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        grant_id,
    output logic              cfg_done,
    output logic              busy,
    output logic              cs,
    output logic              wen,
    output logic [3:0]        addr,
    output logic [31:0]       din,
    input  logic [31:0]       dout
);

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] rr_q, rr_d;
    logic [7:0] byte_q, byte_d;
    logic       cfg_done_q, cfg_done_d;

    logic [2:0] pick_idx;
    logic       pick_any;

    // Only the TXRDY bit of the status word matters.
    logic unused_dout;
    assign unused_dout = ^dout;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req (req_valid),
        .ptr (rr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        byte_d     = byte_q;
        cfg_done_d = cfg_done_q;
        cs         = 1'b0;
        wen        = 1'b0;
        addr       = '0;
        din        = '0;
        req_ready  = '0;
        busy       = 1'b1;

        case (state_q)
            ST_CFG: begin
                cs         = 1'b1;
                wen        = 1'b1;
                addr       = BAUD_ADDR;
                din        = BAUD_CFG;
                cfg_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_any) begin
                    // Byte is captured here; later req_data changes are ignored.
                    grant_d = pick_idx;
                    byte_d  = req_data[8*pick_idx +: 8];
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                cs   = 1'b1;
                addr = STAT_ADDR;
                if (dout[TXRDY_BIT]) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cs                 = 1'b1;
                wen                = 1'b1;
                addr               = DATA_ADDR;
                din                = {24'b0, byte_q};
                req_ready[grant_q] = 1'b1;
                rr_d               = grant_q;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_CFG;
            end
        endcase

        // Reset is synchronous, but the bus must already be quiet during the
        // reset cycles themselves, whatever state the flops still hold.
        if (reset) begin
            cs        = 1'b0;
            wen       = 1'b0;
            addr      = '0;
            din       = '0;
            req_ready = '0;
            busy      = 1'b1;
        end
    end

    assign grant_id = reset ? 3'd0 : grant_q;
    assign cfg_done = reset ? 1'b0 : cfg_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CFG;
            grant_q    <= '0;
            rr_q       <= 3'(NREQ - 1);
            byte_q     <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            byte_q     <= byte_d;
            cfg_done_q <= cfg_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a minimal UART status model.
// Latency: n/a.
// Backpressure: UART readiness driven by uart_rdy.
module tb_uart_tx_sched;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  grant_id;
    logic        cfg_done;
    logic        busy;
    logic        cs;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        uart_rdy;

    always #5 clk = ~clk;

    // UART status register: bit1 = TX ready, combinational on a read of address 2.
    assign dout = (cs && !wen && addr == 4'd2) ? {30'b0, uart_rdy, 1'b0} : 32'h0;

    uart_tx_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .cs        (cs),
        .wen       (wen),
        .addr      (addr),
        .din       (din),
        .dout      (dout)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;
    logic prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus hygiene watched every cycle.
    always @(negedge clk) begin
        if (req_ready != 4'b0) begin
            pulses++;
            chk("rdy_not_back_to_back", {31'b0, prev_rdy}, 32'd0);
            chk("rdy_only_in_data_write", {29'b0, cs, wen, addr == 4'd0}, 32'h7);
        end
        if (!wen) chk("din_zero_when_read", din, 32'd0);
        if (!busy) chk("no_cs_in_idle", {31'b0, cs}, 32'd0);
        prev_rdy = |req_ready;
    end

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          busy_n;     // status reads returning not-ready before ready
        bit          change;     // overwrite req_data with FF while polling
        bit          drop;       // drop req_valid right after lock
        logic [31:0] exp_din;
        logic [3:0]  exp_rdy;
        logic [2:0]  exp_gid;
        int          exp_polls;
        int          exp_wcyc;   // cycles from request to data write
    } vec_t;

    vec_t vecs[4];

    task automatic do_vec(input vec_t v);
        int polls = 0;
        bit got   = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0001 << v.id;
        req_data[8*v.id +: 8] = v.data;
        uart_rdy = (v.busy_n == 0);
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(negedge clk);
            if (cs && wen && addr == 4'd0) begin
                got = 1'b1;
                chk("vec_din", din, v.exp_din);
                chk("vec_req_ready", 32'(req_ready), 32'(v.exp_rdy));
                chk("vec_grant_id", 32'(grant_id), 32'(v.exp_gid));
                chk("vec_status_reads", 32'(polls), 32'(v.exp_polls));
                chk("vec_write_cycle", 32'(cyc), 32'(v.exp_wcyc));
            end else if (cs && !wen && addr == 4'd2) begin
                polls++;
            end
            if (!got) begin
                @(posedge clk); #1;
                uart_rdy = (polls >= v.busy_n);
                if (v.drop && cyc == 0) req_valid = 4'b0;
                if (v.change && polls >= 1) req_data[8*v.id +: 8] = 8'hFF;
            end
        end
        if (!got) chk("vec_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b0;
    endtask

    // Holds req_valid as set by caller and collects n data writes.
    task automatic run_stream(input int n, input logic [39:0] exp_b, input logic [19:0] exp_r);
        int nw   = 0;
        int last = 0;
        for (int cyc = 0; cyc < 200 && nw < n; cyc++) begin
            @(negedge clk);
            if (cs && wen && addr == 4'd0) begin
                chk("stream_byte", din, {24'b0, exp_b[8*nw +: 8]});
                chk("stream_req_ready", 32'(req_ready), 32'(exp_r[4*nw +: 4]));
                if (nw > 0) chk("stream_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                nw++;
            end
        end
        chk("stream_count", 32'(nw), 32'(n));
        @(posedge clk); #1;
        req_valid = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_cnt;
        int p0;
        int wc;
        bit got;

        //               id data  busy chg drp  din        rdy      gid polls wcyc
        vecs[0] = '{2, 8'h41,  0, 0, 0, 32'h41, 4'b0100, 3'd2,  1,  2};
        vecs[1] = '{0, 8'h5A, 20, 0, 0, 32'h5A, 4'b0001, 3'd0, 21, 22};
        vecs[2] = '{1, 8'h42,  2, 1, 0, 32'h42, 4'b0010, 3'd1,  3,  4};
        vecs[3] = '{3, 8'hC3,  1, 0, 1, 32'hC3, 4'b1000, 3'd3,  2,  3};

        reset     = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h0;
        uart_rdy  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'b0, cs}, 32'd0);
        chk("rst_wen", {31'b0, wen}, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_cfg_done", {31'b0, cfg_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);

        // Baud write, then quiet idle.
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("cfg_cs_wen", {30'b0, cs, wen}, 32'h3);
        chk("cfg_addr", 32'(addr), 32'd1);
        chk("cfg_din", din, 32'd3);
        chk("cfg_done_during_cfg", {31'b0, cfg_done}, 32'd0);
        cs_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cs_cnt += int'(cs);
        end
        chk("idle_cfg_done", {31'b0, cfg_done}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_no_cs", 32'(cs_cnt), 32'd0);

        // Single-requester vectors.
        for (int i = 0; i < 4; i++) do_vec(vecs[i]);

        // All four requesting; last grant was requester 3, so 0 goes first.
        req_data  = {8'h70, 8'h49, 8'h62, 8'h41};
        req_valid = 4'b1111;
        uart_rdy  = 1'b1;
        run_stream(5, {8'h41, 8'h70, 8'h49, 8'h62, 8'h41},
                      {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001});

        // Requester 0 was served last: 0 and 2 together must give 2 first.
        req_valid = 4'b0101;
        run_stream(2, {24'h0, 8'h41, 8'h49}, {12'h0, 4'b0001, 4'b0100});

        // Reset while polling a locked byte.
        req_valid = 4'b0010;
        req_data[15:8] = 8'h37;
        uart_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_in_poll", {29'b0, cs, wen, addr == 4'd2}, 32'h5);
        p0 = pulses;
        @(posedge clk); #1;
        reset = 1'b1;
        req_data[15:8] = 8'h38;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        uart_rdy = 1'b1;
        @(negedge clk);
        chk("rerun_cfg_cs_wen", {30'b0, cs, wen}, 32'h3);
        chk("rerun_cfg_addr", 32'(addr), 32'd1);
        chk("rerun_cfg_din", din, 32'd3);
        chk("no_pulse_on_reset", 32'(pulses - p0), 32'd0);
        got = 1'b0;
        wc  = 0;
        for (int cyc = 1; cyc < 50 && !got; cyc++) begin
            @(negedge clk);
            if (cs && wen && addr == 4'd0) begin
                got = 1'b1;
                wc  = cyc;
                chk("after_reset_din", din, 32'h38);
                chk("after_reset_req_ready", 32'(req_ready), 32'b0010);
            end
        end
        chk("after_reset_write_cycle", 32'(wc), 32'd3);
        @(posedge clk); #1;
        req_valid = 4'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
